// File: rtl/lsu_mem_initiator_if.sv
// Bundle of the CPU request/response channels and the data RAM port used by
// the load/store initiator. The slave modport is the initiator's view; the
// master modport is the view of whatever surrounds it (CPU datapath plus RAM).
interface lsu_mem_initiator_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [31:0]              resp_rdata;
  logic                     resp_err;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator. One request at a time: loads read the aligned
// word and extract/extend a lane; SW writes directly; SB/SH do a
// read-modify-write on the aligned word. All outputs come from registers.
module lsu_mem_initiator #(
  parameter int ADDRESS_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  lsu_mem_initiator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t                   state_r;
  logic                     write_r;
  logic [2:0]               funct3_r;
  logic [1:0]               lane_r;
  logic [15:0]              wdata_r;
  logic                     ready_r;
  logic                     resp_valid_r;
  logic                     resp_err_r;
  logic [31:0]              resp_rdata_r;
  logic [ADDRESS_WIDTH-1:0] mem_addr_r;
  logic                     mem_we_r;
  logic [31:0]              mem_wdata_r;

  // Illegal funct3 (011, 11x, stores with 1xx) or a lane misaligned for its size.
  function automatic logic req_bad(input logic write, input logic [2:0] funct3,
                                   input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    case (funct3)
      3'b000:  begin illegal = 1'b0;  misaligned = 1'b0;           end
      3'b001:  begin illegal = 1'b0;  misaligned = lane[0];        end
      3'b010:  begin illegal = 1'b0;  misaligned = (lane != 2'b00); end
      3'b100:  begin illegal = write; misaligned = 1'b0;           end
      3'b101:  begin illegal = write; misaligned = lane[0];        end
      default: begin illegal = 1'b1;  misaligned = 1'b0;           end
    endcase
    return illegal | misaligned;
  endfunction

  // Pick the addressed byte/half out of the word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] funct3,
                                               input logic [1:0] lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store byte/half onto the word read back from RAM.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0] funct3,
                                              input logic [1:0] lane,
                                              input logic [15:0] data);
    logic [31:0] r;
    r = word;
    case (funct3[1:0])
      2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = data;
      default: r = word;
    endcase
    return r;
  endfunction

  assign bus.req_ready  = ready_r & rst_n;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_wdata  = mem_wdata_r;

  // Control FSM; every output is registered alongside the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      write_r      <= 1'b0;
      funct3_r     <= 3'd0;
      lane_r       <= 2'd0;
      wdata_r      <= 16'd0;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      mem_addr_r   <= '0;
      mem_we_r     <= 1'b0;
      mem_wdata_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            write_r  <= bus.req_write;
            funct3_r <= bus.req_funct3;
            lane_r   <= bus.req_addr[1:0];
            wdata_r  <= bus.req_wdata[15:0];
            ready_r  <= 1'b0;
            if (req_bad(bus.req_write, bus.req_funct3, bus.req_addr[1:0])) begin
              // Errors go straight to the response and never reach RAM.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
            end else if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
              state_r     <= WRITE;
              mem_addr_r  <= {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
              mem_we_r    <= 1'b1;
              mem_wdata_r <= bus.req_wdata;
            end else begin
              state_r    <= READ;
              mem_addr_r <= {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
            end
          end
        end
        READ: begin
          if (write_r) begin
            // Address is held; the merged word is written next cycle.
            state_r     <= WRITE;
            mem_we_r    <= 1'b1;
            mem_wdata_r <= store_merge(bus.mem_rdata, funct3_r, lane_r, wdata_r);
          end else begin
            state_r      <= RESP;
            mem_addr_r   <= '0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= load_extract(bus.mem_rdata, funct3_r, lane_r);
          end
        end
        WRITE: begin
          state_r      <= RESP;
          mem_addr_r   <= '0;
          mem_we_r     <= 1'b0;
          mem_wdata_r  <= 32'd0;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
          end
        end
        default: begin
          state_r      <= IDLE;
          ready_r      <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
          mem_addr_r   <= '0;
          mem_we_r     <= 1'b0;
          mem_wdata_r  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: a fixed vector table from the
// plan, hand-written backpressure/reset sequences, then random requests
// checked against a byte-array reference model.
module tb_lsu_mem_initiator;

  logic clk;
  logic rst_n;

  lsu_mem_initiator_if #(.ADDRESS_WIDTH(32)) bus ();

  lsu_mem_initiator #(.ADDRESS_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM behind the port: combinational read, write on the clock edge.
  logic [31:0] ram_w [0:1023] = '{default: 32'd0};
  assign bus.mem_rdata = ram_w[bus.mem_addr[11:2]];
  always @(posedge clk) if (bus.mem_we) ram_w[bus.mem_addr[11:2]] <= bus.mem_wdata;

  // Reference model memory, byte-addressed by addr[11:0].
  logic [7:0] mm [0:4095];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Expected outcome of one request from the ISA rules; updates model memory.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] er, output logic ee,
                                output int el, output int ewe, output logic [31:0] eword);
    int size;
    int base;
    bit illegal;
    bit mis;
    longint v;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3[2:1] == 2'b11) || (wr && f3[2]);
    mis     = !illegal && ((int'(addr[11:0]) % size) != 0);
    base    = int'(addr[11:0]) & ~3;
    er = 32'd0; ee = 1'b0; el = 0; ewe = 0; eword = 32'd0;
    if (illegal || mis) begin
      ee = 1'b1; el = 1;
    end else if (wr) begin
      for (int i = 0; i < size; i++) mm[int'(addr[11:0]) + i] = wd[8*i +: 8];
      el    = (size == 4) ? 2 : 3;
      ewe   = 1;
      eword = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mm[int'(addr[11:0]) + i]) << (8*i));
      if (!f3[2] && v[8*size-1]) v = v - (64'sd1 << (8*size));
      er = v[31:0];
      el = 2;
    end
  endfunction

  // Issue one request, observe the response and RAM activity, then accept it.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold, input bit junk,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int we_cnt, output int we_cyc,
                         output logic [31:0] we_addr, output logic [31:0] we_data);
    bit found;
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = junk;
    if (junk) begin
      bus.req_write  = 1'($urandom_range(0, 1));
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr   = 32'h0001_0000 + 32'($urandom_range(0, 63));
      bus.req_wdata  = $urandom;
    end
    found = 1'b0; lat = 0; we_cnt = 0; we_cyc = 0;
    we_addr = 32'd0; we_data = 32'd0; rdata = 32'd0; err = 1'b0;
    for (int c = 1; c <= 12 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        we_cnt++; we_cyc = c; we_addr = bus.mem_addr; we_data = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        found = 1'b1; lat = c;
      end
    end
    if (!found) begin
      chk("resp_timeout", 32'(bus.resp_valid), 32'd1);
    end else begin
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      chk("mem_addr_in_resp", bus.mem_addr, 32'd0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (bus.mem_we) we_cnt++;
        chk("hold_valid", 32'(bus.resp_valid), 32'd1);
        chk("hold_rdata", bus.resp_rdata, rdata);
        chk("hold_err", 32'(bus.resp_err), 32'(err));
        chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    if (found) chk("resp_drop", 32'(bus.resp_valid), 32'd0);
  endtask

  // Run one request and compare everything observable with the expectations.
  task automatic check_req(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int hold,
                           input bit junk, input logic [31:0] er, input logic ee, input int el,
                           input int ewe, input logic [31:0] eword);
    logic [31:0] rdata, we_addr, we_data;
    logic err;
    int lat, we_cnt, we_cyc;
    run_req(wr, f3, addr, wd, hold, junk, rdata, err, lat, we_cnt, we_cyc, we_addr, we_data);
    chk({tag, "_rdata"}, rdata, er);
    chk({tag, "_err"}, 32'(err), 32'(ee));
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_we_count"}, 32'(we_cnt), 32'(ewe));
    if (ewe == 1) begin
      chk({tag, "_we_cycle"}, 32'(we_cyc), 32'(el - 1));
      chk({tag, "_we_addr"}, we_addr, {addr[31:2], 2'b00});
      chk({tag, "_we_data"}, we_data, eword);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] er;
    logic        ee;
    int          el;
    int          ewe;
    logic [31:0] eword;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] er, eword;
    logic        ee, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd;
    int          el, ewe;

    for (int i = 0; i < 4096; i++) mm[i] = 8'd0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b0;

    //           wr    f3     addr          wdata         hold rdata         err  lat we word
    tbl[0]  = '{1'b1, 3'd2, 32'h0001_0000, 32'h1234_5678, 0, 32'h0000_0000, 1'b0, 2, 1, 32'h1234_5678};
    tbl[1]  = '{1'b0, 3'd2, 32'h0001_0000, 32'h0,         5, 32'h1234_5678, 1'b0, 2, 0, 32'h0};
    tbl[2]  = '{1'b0, 3'd0, 32'h0001_0001, 32'h0,         0, 32'h0000_0056, 1'b0, 2, 0, 32'h0};
    tbl[3]  = '{1'b1, 3'd0, 32'h0001_0002, 32'h0000_00AB, 0, 32'h0000_0000, 1'b0, 3, 1, 32'h12AB_5678};
    tbl[4]  = '{1'b0, 3'd2, 32'h0001_0000, 32'h0,         0, 32'h12AB_5678, 1'b0, 2, 0, 32'h0};
    tbl[5]  = '{1'b1, 3'd0, 32'h0001_0001, 32'hFFFF_FF9A, 0, 32'h0000_0000, 1'b0, 3, 1, 32'h12AB_9A78};
    tbl[6]  = '{1'b0, 3'd0, 32'h0001_0001, 32'h0,         0, 32'hFFFF_FF9A, 1'b0, 2, 0, 32'h0};
    tbl[7]  = '{1'b0, 3'd4, 32'h0001_0001, 32'h0,         0, 32'h0000_009A, 1'b0, 2, 0, 32'h0};
    tbl[8]  = '{1'b1, 3'd1, 32'h0001_0006, 32'h5555_8001, 0, 32'h0000_0000, 1'b0, 3, 1, 32'h8001_0000};
    tbl[9]  = '{1'b0, 3'd1, 32'h0001_0006, 32'h0,         0, 32'hFFFF_8001, 1'b0, 2, 0, 32'h0};
    tbl[10] = '{1'b0, 3'd5, 32'h0001_0006, 32'h0,         0, 32'h0000_8001, 1'b0, 2, 0, 32'h0};
    tbl[11] = '{1'b0, 3'd2, 32'h0001_0002, 32'h0,         0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
    tbl[12] = '{1'b0, 3'd1, 32'h0001_0001, 32'h0,         0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
    tbl[13] = '{1'b1, 3'd4, 32'h0001_0000, 32'h0000_00EE, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
    tbl[14] = '{1'b0, 3'd3, 32'h0001_0000, 32'h0,         0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
    tbl[15] = '{1'b0, 3'd6, 32'h0001_0000, 32'h0,         0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};
    tbl[16] = '{1'b1, 3'd1, 32'h0001_0003, 32'h0000_1234, 0, 32'h0000_0000, 1'b1, 1, 0, 32'h0};

    // Reset state while rst_n is low, then after release.
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready_low", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready_release", 32'(bus.req_ready), 32'd1);

    // Directed table; the model is stepped too so its memory stays in sync.
    for (int i = 0; i < 17; i++) begin
      model(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, er, ee, el, ewe, eword);
      check_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                tbl[i].hold, 1'b0, tbl[i].er, tbl[i].ee, tbl[i].el, tbl[i].ewe, tbl[i].eword);
    end

    // Reset landing mid-cycle during the WRITE of an SW: no RAM write happens.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h0001_0008; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("sw_write_we", 32'(bus.mem_we), 32'd1);
    chk("sw_write_addr", bus.mem_addr, 32'h0001_0008);
    chk("sw_write_data", bus.mem_wdata, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("midrst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_req_ready_release", 32'(bus.req_ready), 32'd1);

    // Random requests against the reference model, with junk on req_* while busy.
    for (int n = 0; n < 300; n++) begin
      wr   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h0001_0000 + 32'($urandom_range(0, 63));
      wd   = $urandom;
      model(wr, f3, addr, wd, er, ee, el, ewe, eword);
      check_req($sformatf("rnd%0d", n), wr, f3, addr, wd, $urandom_range(0, 2), 1'b1,
                er, ee, el, ewe, eword);
    end

    // Final RAM contents must match the model byte for byte.
    for (int w = 0; w < 17; w++) begin
      chk($sformatf("ram_word%0d", w), ram_w[w],
          {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
